multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle variant of the RV32 core. It replaces the purely combinational opcode decode with a sequenced FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK flow over one shared ALU and one shared instruction/data memory port.
- Memory accesses use a req/ready handshake, and a bounded wait timeout sends the core to a trap state.
- Supported opcodes: R-type 0110011, I-ALU 0010011, LW 0000011, SW 0100011, B-type 1100011.

Parameters:
- TIMEOUT_CYCLES, 16, maximum consecutive cycles a memory state waits with mem_ready low before entering TRAP (must be ≥ 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- op  input  7  opcode field from instruction register; valid from DECODE onward.
- mem_ready  input  1  memory completes current access this cycle.
- branch_cond  input  1  datapath-evaluated branch condition (BEQ/BNE/BLT/BGE).
- pc_write  output  1  PC register load enable.
- ir_write  output  1  instruction register load enable.
- reg_write  output  1  register file write enable.
- mem_req  output  1  memory access request.
- mem_we  output  1  memory write (valid with mem_req).
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- alu_src_a  output  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  output  2  ALU B mux: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  output  2  00 = add, 01 = compare/subtract, 10 = funct-decoded.
- imm_src  output  2  01 for SW, 10 for B-type, 00 otherwise (combinational on op, all states).
- result_src  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result direct.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  high while in TRAP.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEM_ADR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9, TRAP = 10.
- Reset:
  - While rst = 0 at a clk edge: state ← FETCH, wait counter ← 0.
  - All outputs are 0 while rst is low, including imm_src.
  - The first cycle after release is FETCH.
  - Reset mid-instruction aborts it with no write and no instr_done.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - mem_ready → DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into ALUOut).
  - Next state by op: 0000011 or 0100011 → MEM_ADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; any other → TRAP.
- MEM_ADR:
  - Outputs: alu_src_a = 10, alu_src_b = 01, alu_op = 00.
  - Next state: LW → MEM_RD, SW → MEM_WR.
- MEM_RD:
  - Outputs: mem_req = 1, adr_src = 1.
  - mem_ready → MEM_WB.
- MEM_WB:
  - Outputs: reg_write = 1, result_src = 01, instr_done = 1.
  - Next state → FETCH.
- MEM_WR:
  - Outputs: mem_req = 1, mem_we = 1, adr_src = 1.
  - mem_ready → FETCH, with instr_done = 1 in that cycle.
- EXEC_R:
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 10.
  - Next state → ALU_WB.
- EXEC_I:
  - Outputs: alu_src_a = 10, alu_src_b = 01, alu_op = 10.
  - Next state → ALU_WB.
- ALU_WB:
  - Outputs: reg_write = 1, result_src = 00, instr_done = 1.
  - Next state → FETCH.
- BRANCH:
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, pc_write = branch_cond, instr_done = 1.
  - Next state → FETCH.
- TRAP:
  - Outputs: illegal = 1; all enables and requests are 0.
  - Stays in TRAP until reset.
- Memory wait timeout:
  - Wait counter (ceil(log2(TIMEOUT_CYCLES)) bits) increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready = 0.
  - It clears on any state change.
  - If counter = TIMEOUT_CYCLES−1 and mem_ready = 0 → TRAP next cycle. The maximum wait is therefore TIMEOUT_CYCLES stall cycles.
  - If mem_ready arrives in that same cycle, completion wins.
- Latency with mem_ready tied to 1:
  - R/I-ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - B-type: 3 cycles.
  - Each memory stall cycle adds 1.
- mem_req stays high and adr_src/mem_we stay stable until mem_ready. The controller never drops a request before completion, except on reset or timeout.

Test Plan:
- rst low 3 cycles, then op = 0110011, mem_ready = 1 → all outputs 0 during reset; states 0, 1, 6, 8; reg_write and instr_done high in cycle 4 only; back to FETCH in cycle 5.
- LW (0000011), mem_ready low 2 cycles in both FETCH and MEM_RD → mem_req held 3 cycles in each; MEM_WB asserts result_src = 01 and reg_write = 1; total 9 cycles.
- SW (0100011), mem_ready = 1 → MEM_WR with mem_req = mem_we = adr_src = 1, instr_done = 1, reg_write never 1; 4 cycles.
- B-type with branch_cond = 1, then a second B-type with branch_cond = 0 → pc_write = 1 / 0 in BRANCH; each instruction takes 3 cycles.
- TIMEOUT_CYCLES = 16, mem_ready held 0 in FETCH → TRAP entered after 16 stall cycles, illegal = 1 and mem_req = 0 thereafter. Repeat with mem_ready = 1 on stall cycle 16 → DECODE, no trap.
- op = 1111111 in DECODE → TRAP, illegal = 1 and remains set. Assert rst low for 1 cycle → FETCH, illegal = 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing
// over a shared ALU and memory port, with a bounded memory-wait trap.
//
// Ports:
//   clk, rst (sync, active-low)
//   op[6:0]       opcode from the instruction register
//   mem_ready     memory completes the current access this cycle
//   branch_cond   datapath branch outcome
//   pc_write, ir_write, reg_write, mem_req, mem_we, adr_src
//   alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]
//   imm_src[1:0], result_src[1:0]
//   instr_done    one-cycle retire pulse
//   illegal       high while trapped
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       branch_cond,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_TRAP    = 4'd10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic is_r, is_i, is_lw, is_sw, is_b;
  logic waiting;

  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_I);
  assign is_lw = (op == OP_LW);
  assign is_sw = (op == OP_SW);
  assign is_b  = (op == OP_B);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        waiting = 1'b1;
        if (mem_ready)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEM_ADR;
          is_r:         state_d = S_EXEC_R;
          is_i:         state_d = S_EXEC_I;
          is_b:         state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        unique case (1'b1)
          is_lw:   state_d = S_MEM_RD;
          is_sw:   state_d = S_MEM_WR;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM_RD: begin
        waiting = 1'b1;
        if (mem_ready)
          state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        waiting = 1'b1;
        if (mem_ready)
          state_d = S_FETCH;
      end
      S_MEM_WB: state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALU_WB;
      S_EXEC_I: state_d = S_ALU_WB;
      S_ALU_WB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase

    // Completion has priority over the timeout.
    if (waiting && !mem_ready &&
        cnt_q == CNT_MAX)
      state_d = S_TRAP;
  end

  // Stall counter: clears on any state change
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (waiting && !mem_ready)
      cnt_d = cnt_q + 1'b1;
  end

  // Outputs
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    if (is_sw)
      imm_src = 2'b01;
    else if (is_b)
      imm_src = 2'b10;

    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = branch_cond;
        instr_done = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase

    if (!rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      imm_src    = 2'b00;
      result_src = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle scoreboard of
// expected control vectors plus literal instruction latencies.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic       mem_ready = 1'b0;
  logic       branch_cond = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_req, mem_we, adr_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, imm_src, result_src;
  logic       instr_done, illegal;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] XX = 7'b1111111;

  multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .branch_cond(branch_cond), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_req(mem_req),
    .mem_we(mem_we), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .result_src(result_src), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum {
    PH_RST, PH_FETCH, PH_DECODE, PH_MEM_ADR, PH_MEM_RD, PH_MEM_WB,
    PH_MEM_WR, PH_EXEC_R, PH_EXEC_I, PH_ALU_WB, PH_BRANCH, PH_TRAP
  } ph_t;

  typedef struct {
    logic        r;
    logic [6:0]  op;
    logic        rdy;
    logic        bc;
    logic [17:0] exp;
    int          lat;
    string       nm;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  bit   cur_v = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ncyc = 0;

  // Expected control word for one cycle, straight from the
  // per-phase output table.
  function automatic logic [17:0] model(ph_t ph, logic [6:0] o,
                                        logic rdy, logic bc);
    logic pc, ir, rw, rq, we, ad, dn, il;
    logic [1:0] a, b, ao, im, rs;
    {pc, ir, rw, rq, we, ad, dn, il} = '0;
    {a, b, ao, im, rs} = '0;
    if (ph == PH_RST) return '0;
    im = (o == SW) ? 2'b01 : (o == B) ? 2'b10 : 2'b00;
    case (ph)
      PH_FETCH: begin
        rq = 1; b = 2'b10; rs = 2'b10; ir = rdy; pc = rdy;
      end
      PH_DECODE:  begin a = 2'b01; b = 2'b01; end
      PH_MEM_ADR: begin a = 2'b10; b = 2'b01; end
      PH_MEM_RD:  begin rq = 1; ad = 1; end
      PH_MEM_WB:  begin rw = 1; rs = 2'b01; dn = 1; end
      PH_MEM_WR:  begin rq = 1; we = 1; ad = 1; dn = rdy; end
      PH_EXEC_R:  begin a = 2'b10; ao = 2'b10; end
      PH_EXEC_I:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      PH_ALU_WB:  begin rw = 1; dn = 1; end
      PH_BRANCH:  begin a = 2'b10; ao = 2'b01; pc = bc; dn = 1; end
      PH_TRAP:    il = 1;
      default: ;
    endcase
    return {pc, ir, rw, rq, we, ad, a, b, ao, im, rs, dn, il};
  endfunction

  task automatic push(input logic r, input logic [6:0] o,
                      input logic rdy, input logic bc,
                      input ph_t ph, input int lat);
    rec_t x;
    x.r = r; x.op = o; x.rdy = rdy; x.bc = bc; x.lat = lat;
    x.exp = r ? model(ph, o, rdy, bc) : 18'd0;
    x.nm = r ? ph.name() : "RESET";
    q.push_back(x);
  endtask

  task automatic do_reset(input int n, input logic [6:0] o);
    for (int k = 0; k < n; k++) push(1'b0, o, 1'b1, 1'b0, PH_RST, 0);
  endtask

  // One instruction: fs FETCH stalls, ms memory-stage stalls.
  task automatic instr(input logic [6:0] o, input int fs,
                       input int ms, input logic bc, input int lat);
    for (int k = 0; k < fs; k++) push(1, o, 0, bc, PH_FETCH, 0);
    push(1, o, 1, bc, PH_FETCH, 0);
    push(1, o, 1, bc, PH_DECODE, 0);
    case (o)
      R: begin
        push(1, o, 1, bc, PH_EXEC_R, 0);
        push(1, o, 1, bc, PH_ALU_WB, lat);
      end
      I: begin
        push(1, o, 1, bc, PH_EXEC_I, 0);
        push(1, o, 1, bc, PH_ALU_WB, lat);
      end
      LW: begin
        push(1, o, 1, bc, PH_MEM_ADR, 0);
        for (int k = 0; k < ms; k++) push(1, o, 0, bc, PH_MEM_RD, 0);
        push(1, o, 1, bc, PH_MEM_RD, 0);
        push(1, o, 1, bc, PH_MEM_WB, lat);
      end
      SW: begin
        push(1, o, 1, bc, PH_MEM_ADR, 0);
        for (int k = 0; k < ms; k++) push(1, o, 0, bc, PH_MEM_WR, 0);
        push(1, o, 1, bc, PH_MEM_WR, lat);
      end
      B: push(1, o, 1, bc, PH_BRANCH, lat);
      default: push(1, o, 1, bc, PH_TRAP, 0);
    endcase
  endtask

  // Compare process
  always @(negedge clk) begin
    if (cur_v) begin
      tests++;
      if ({pc_write, ir_write, reg_write, mem_req, mem_we, adr_src,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src,
           instr_done, illegal} !== cur.exp) begin
        fails++;
        $display("FAIL cyc%0d %s op=%b rdy=%b: got %b want %b",
          ncyc, cur.nm, cur.op, cur.rdy,
          {pc_write, ir_write, reg_write, mem_req, mem_we, adr_src,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src,
           instr_done, illegal}, cur.exp);
      end
      if (!cur.r) cyc = 0;
      else cyc++;
      if (cur.lat != 0) begin
        tests++;
        if (!instr_done || cyc != cur.lat) begin
          fails++;
          $display("FAIL cyc%0d latency: got %0d done=%b want %0d",
                   ncyc, cyc, instr_done, cur.lat);
        end
      end
      if (instr_done) cyc = 0;
      ncyc++;
    end
  end

  initial begin
    // Reset, then R-type with ready tied high
    do_reset(3, R);
    instr(R, 0, 0, 0, 4);
    // LW with two stalls in FETCH and MEM_RD
    instr(LW, 2, 2, 0, 9);
    instr(SW, 0, 0, 0, 4);
    instr(B, 0, 0, 1, 3);
    instr(B, 0, 0, 0, 3);
    instr(I, 0, 0, 0, 4);
    instr(SW, 0, 3, 0, 7);
    // Abort an LW mid-flight
    push(1, LW, 1, 0, PH_FETCH, 0);
    push(1, LW, 1, 0, PH_DECODE, 0);
    push(1, LW, 1, 0, PH_MEM_ADR, 0);
    do_reset(1, LW);
    instr(R, 0, 0, 0, 4);
    // Timeout: 16 stalls in FETCH, then trapped
    do_reset(1, R);
    for (int k = 0; k < 16; k++) push(1, R, 0, 0, PH_FETCH, 0);
    for (int k = 0; k < 4; k++) push(1, R, k[0], 0, PH_TRAP, 0);
    // Ready on the 16th FETCH cycle completes instead
    do_reset(1, R);
    instr(R, 15, 0, 0, 19);
    instr(LW, 0, 15, 0, 20);
    // MEM_RD timeout
    push(1, LW, 1, 0, PH_FETCH, 0);
    push(1, LW, 1, 0, PH_DECODE, 0);
    push(1, LW, 1, 0, PH_MEM_ADR, 0);
    for (int k = 0; k < 16; k++) push(1, LW, 0, 0, PH_MEM_RD, 0);
    push(1, LW, 0, 0, PH_TRAP, 0);
    // Illegal opcode
    do_reset(1, R);
    instr(XX, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) push(1, XX, 1, 0, PH_TRAP, 0);
    do_reset(1, R);
    instr(R, 0, 0, 0, 4);

    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      cur = q.pop_front();
      rst = cur.r;
      op = cur.op;
      mem_ready = cur.rdy;
      branch_cond = cur.bc;
      cur_v = 1'b1;
    end
    @(posedge clk);
    #1 cur_v = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
